// File: rtl/simple_average_filter_pkg.sv
// Shared defaults and helpers for the moving-average filter.
package simple_average_filter_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 12;
    localparam int DEFAULT_WINDOW_SIZE = 16;

    // Exact log2 of a power of two; non-powers return 0 and are rejected by the top.
    function automatic int log2_pow2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) == n) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/avg_delay_line.sv
// Circular delay line of the last WINDOW_SIZE samples; oldest_o is the entry about to be overwritten.
module avg_delay_line
    import simple_average_filter_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int WINDOW_SIZE = DEFAULT_WINDOW_SIZE,
    parameter int PTR_W       = log2_pow2(WINDOW_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] wr_data_i,
    output logic signed [DATA_WIDTH-1:0] oldest_o
);

    logic signed [DATA_WIDTH-1:0] mem_q [WINDOW_SIZE];
    logic        [PTR_W-1:0]      ptr_q;
    logic        [PTR_W-1:0]      ptr_d;

    always_comb begin
        ptr_d = ptr_q + PTR_W'(1);
        if (ptr_q == PTR_W'(WINDOW_SIZE - 1)) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WINDOW_SIZE; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '0;
        end else begin
            mem_q[ptr_q] <= wr_data_i;
            ptr_q        <= ptr_d;
        end
    end

    // The slot under the write pointer holds the sample captured WINDOW_SIZE edges ago.
    assign oldest_o = mem_q[ptr_q];

endmodule

// File: rtl/simple_average_filter.sv
// Moving average over WINDOW_SIZE signed samples using a running-sum accumulator.
// Define SIMPLE_AVERAGE_FILTER_ROUND_EN for round-half-up output instead of floor.
module simple_average_filter
    import simple_average_filter_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int WINDOW_SIZE = DEFAULT_WINDOW_SIZE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic signed [DATA_WIDTH-1:0] data_out
);

    localparam int LOG2W = log2_pow2(WINDOW_SIZE);
    localparam int ACC_W = DATA_WIDTH + LOG2W;

    if (WINDOW_SIZE < 2 || (WINDOW_SIZE & (WINDOW_SIZE - 1)) != 0) begin : g_bad_window
        $error("simple_average_filter: WINDOW_SIZE must be a power of two >= 2");
    end

    logic signed [DATA_WIDTH-1:0] oldest;
    logic signed [ACC_W-1:0]      new_ext;
    logic signed [ACC_W-1:0]      old_ext;
    logic signed [ACC_W-1:0]      sum_q;
    logic signed [ACC_W-1:0]      sum_d;

    avg_delay_line #(
        .DATA_WIDTH (DATA_WIDTH),
        .WINDOW_SIZE(WINDOW_SIZE),
        .PTR_W      (LOG2W)
    ) u_delay_line (
        .clk      (clk),
        .rst      (rst),
        .wr_data_i(data_in),
        .oldest_o (oldest)
    );

    assign new_ext = {{LOG2W{data_in[DATA_WIDTH-1]}}, data_in};
    assign old_ext = {{LOG2W{oldest[DATA_WIDTH-1]}}, oldest};
    assign sum_d   = sum_q + new_ext - old_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

`ifdef SIMPLE_AVERAGE_FILTER_ROUND_EN
    // One extra bit so the half-LSB bias cannot overflow a full-scale sum.
    localparam logic signed [ACC_W:0] RND_BIAS = (ACC_W + 1)'(WINDOW_SIZE / 2);
    logic signed [ACC_W:0] rnd_sum;

    assign rnd_sum  = {sum_q[ACC_W-1], sum_q} + RND_BIAS;
    assign data_out = DATA_WIDTH'(rnd_sum >>> LOG2W);
`else
    assign data_out = DATA_WIDTH'(sum_q >>> LOG2W);
`endif

endmodule

// File: tb/tb_simple_average_filter.sv
// Self-checking bench for simple_average_filter against a queue-based window-average model.
module tb_simple_average_filter;

    localparam int DW = 12;
    localparam int W  = 16;

    logic                 clk;
    logic                 rst;
    logic signed [DW-1:0] data_in;
    logic signed [DW-1:0] data_out;

    int errors = 0;
    int checks = 0;
    int hist[$];

    simple_average_filter #(.DATA_WIDTH(DW), .WINDOW_SIZE(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int floor_div(input int num, input int den);
        int q;
        q = num / den;
        if ((num % den) != 0 && num < 0) q = q - 1;
        return q;
    endfunction

    function automatic int model_out();
        int s;
        s = 0;
        foreach (hist[i]) s += hist[i];
`ifdef SIMPLE_AVERAGE_FILTER_ROUND_EN
        s += W / 2;
`endif
        return floor_div(s, W);
    endfunction

    task automatic check_val(input string tag, input logic signed [DW-1:0] exp);
        checks++;
        assert (data_out === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, data_out, exp);
        end
    endtask

    // Drive one edge, advance the model, then check 1ns after the edge.
    task automatic step(input logic r, input logic signed [DW-1:0] d, input string tag);
        logic signed [DW-1:0] exp;
        rst     = r;
        data_in = d;
        @(posedge clk);
        if (r) begin
            hist.delete();
        end else begin
            hist.push_back(int'(d));
            if (hist.size() > W) void'(hist.pop_front());
        end
        #1;
        exp = DW'(model_out());
        check_val(tag, exp);
    endtask

    initial begin
        rst     = 1'b1;
        data_in = '0;

        // Reset flush with unknown and zero input
        for (int i = 0; i < 21; i++) step(1'b1, (i % 2 == 0) ? 'x : '0, "reset_hold");
        for (int i = 0; i < 5; i++)  step(1'b0, '0, "post_reset_zero");

        // Step response
        for (int k = 1; k <= 48; k++) begin
            step(1'b0, 12'sd1000, "step_1000");
`ifndef SIMPLE_AVERAGE_FILTER_ROUND_EN
            if (k == 1)  check_val("step_k1_62", 12'sd62);
            if (k == 3)  check_val("step_k3_187", 12'sd187);
            if (k == 16) check_val("step_k16_1000", 12'sd1000);
            if (k == 48) check_val("step_k48_1000", 12'sd1000);
`endif
        end

        // Impulse
        step(1'b1, '0, "impulse_reset");
        for (int i = 0; i < 16; i++) step(1'b0, '0, "impulse_pre");
        step(1'b0, 12'sd1600, "impulse_hit");
        check_val("impulse_first_100", 12'sd100);
        for (int i = 0; i < 15; i++) step(1'b0, '0, "impulse_hold");
        check_val("impulse_last_100", 12'sd100);
        step(1'b0, '0, "impulse_gone");
        check_val("impulse_after_0", 12'sd0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, "impulse_tail");

        // Extremes
        for (int i = 0; i < 20; i++) step(1'b0, -12'sd2048, "min_const");
        check_val("min_settled", -12'sd2048);
        for (int i = 0; i < 20; i++) step(1'b0, 12'sd2047, "max_const");
        check_val("max_settled", 12'sd2047);

        // Quantization of a single small sample
        step(1'b1, '0, "quant_reset");
        step(1'b0, 12'sd8, "quant_pos8");
`ifdef SIMPLE_AVERAGE_FILTER_ROUND_EN
        check_val("quant_pos8_round", 12'sd1);
`else
        check_val("quant_pos8_floor", 12'sd0);
`endif
        for (int i = 0; i < 16; i++) step(1'b0, '0, "quant_flush");
        step(1'b0, -12'sd8, "quant_neg8");
`ifdef SIMPLE_AVERAGE_FILTER_ROUND_EN
        check_val("quant_neg8_round", 12'sd0);
`else
        check_val("quant_neg8_floor", -12'sd1);
`endif
        for (int i = 0; i < 16; i++) step(1'b0, '0, "quant_flush2");

        // Mid-run reset during a step
        for (int i = 0; i < 6; i++) step(1'b0, 12'sd1000, "midrun_pre");
        step(1'b1, 12'sd1000, "midrun_rst");
        check_val("midrun_rst_zero", 12'sd0);
        step(1'b0, 12'sd1000, "midrun_restart");
`ifndef SIMPLE_AVERAGE_FILTER_ROUND_EN
        check_val("midrun_restart_62", 12'sd62);
`endif
        for (int i = 0; i < 20; i++) step(1'b0, 12'sd1000, "midrun_ramp");

        // Random samples with occasional resets
        for (int i = 0; i < 300; i++) begin
            logic signed [DW-1:0] d;
            logic                 r;
            d = DW'($urandom_range(0, 4095));
            r = ($urandom_range(0, 59) == 0);
            step(r, d, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
